// File: rtl/fft_operand_feeder.sv
// Operand source for the first radix-2 DIF stage of a 16-point FFT: gathers one
// 16-sample frame, then presents the 8 butterfly pairs (buf[k], buf[k+8], W16^k).
module fft_operand_feeder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_re,
    input  logic [15:0] in_im,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] xr,
    output logic [15:0] xi,
    output logic [15:0] yr,
    output logic [15:0] yi,
    output logic [15:0] wr,
    output logic [15:0] wi,
    output logic [2:0]  out_idx,
    output logic        out_last
);

    typedef enum logic {LOAD, ISSUE} state_t;

    state_t state, state_next;
    logic [3:0] wcnt;
    logic [2:0] k;
    logic [2:0] k_load;
    logic       in_fire, out_fire, load_pair;

    logic signed [15:0] sample_re [16];
    logic signed [15:0] sample_im [16];

    // W16^k in Q1.15, {real, imag}
    function automatic logic [31:0] twiddle(input logic [2:0] idx);
        logic [31:0] w;
        case (idx)
            3'd0:    w = 32'h7FFF_0000;
            3'd1:    w = 32'h7642_CF04;
            3'd2:    w = 32'h5A82_A57E;
            3'd3:    w = 32'h30FC_89BE;
            3'd4:    w = 32'h0000_8001;
            3'd5:    w = 32'hCF04_89BE;
            3'd6:    w = 32'hA57E_A57E;
            default: w = 32'h89BE_CF04;
        endcase
        return w;
    endfunction

    always_comb begin
        state_next = state;
        in_ready   = (state == LOAD);
        out_valid  = (state == ISSUE);
        in_fire    = in_valid && (state == LOAD);
        out_fire   = out_ready && (state == ISSUE);
        load_pair  = 1'b0;
        k_load     = k;
        case (state)
            LOAD: begin
                if (in_fire && wcnt == 4'd15) begin
                    state_next = ISSUE;
                    load_pair  = 1'b1;
                    k_load     = 3'd0;
                end
            end
            ISSUE: begin
                if (out_fire) begin
                    if (k == 3'd7) begin
                        state_next = LOAD;
                    end else begin
                        load_pair = 1'b1;
                        k_load    = k + 3'd1;
                    end
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD;
            wcnt     <= 4'd0;
            k        <= 3'd0;
            xr       <= 16'd0;
            xi       <= 16'd0;
            yr       <= 16'd0;
            yi       <= 16'd0;
            wr       <= 16'd0;
            wi       <= 16'd0;
            out_last <= 1'b0;
        end else begin
            state <= state_next;
            if (in_fire) begin
                wcnt <= wcnt + 4'd1;
            end
            // Pair 0 reads buf[0]/buf[8], both written before the closing handshake
            if (load_pair) begin
                k        <= k_load;
                xr       <= sample_re[{1'b0, k_load}];
                xi       <= sample_im[{1'b0, k_load}];
                yr       <= sample_re[{1'b1, k_load}];
                yi       <= sample_im[{1'b1, k_load}];
                {wr, wi} <= twiddle(k_load);
                out_last <= (k_load == 3'd7);
            end else if (out_fire && k == 3'd7) begin
                k        <= 3'd0;
                out_last <= 1'b0;
            end
        end
    end

    // Frame storage carries no reset; wcnt restarting at 0 discards stale data
    always_ff @(posedge clk) begin
        if (in_fire) begin
            sample_re[wcnt] <= $signed(in_re);
            sample_im[wcnt] <= $signed(in_im);
        end
    end

    assign out_idx = k;

endmodule

// File: tb/tb_fft_operand_feeder.sv
// Randomized bench for fft_operand_feeder against a frame-level reference model.
module tb_fft_operand_feeder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] xr, xi, yr, yi, wr, wi;
    logic [2:0]  out_idx;
    logic        out_last;

    fft_operand_feeder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .xr(xr), .xi(xi), .yr(yr), .yi(yi), .wr(wr), .wi(wi),
        .out_idx(out_idx), .out_last(out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    localparam logic [31:0] TW [8] = '{
        32'h7FFF0000, 32'h7642CF04, 32'h5A82A57E, 32'h30FC89BE,
        32'h00008001, 32'hCF0489BE, 32'hA57EA57E, 32'h89BECF04
    };

    typedef struct {
        logic [15:0] xr, xi, yr, yi, wr, wi;
        logic [2:0]  idx;
        logic        last;
    } beat_t;

    logic [15:0] frame_re[$];
    logic [15:0] frame_im[$];
    beat_t       exp_q[$];

    // Reference model: a frame is a list of accepted samples; a full frame
    // becomes 8 expected operand sets that must be drained before more input.
    always @(negedge clk) begin : model
        bit issuing;
        beat_t b;
        if (!rst_n) begin
            frame_re.delete();
            frame_im.delete();
            exp_q.delete();
        end else begin
            issuing = (exp_q.size() != 0);
            check("in_ready", {31'd0, in_ready}, {31'd0, !issuing});
            check("out_valid", {31'd0, out_valid}, {31'd0, issuing});
            if (issuing) begin
                b = exp_q[0];
                check("xr", {16'd0, xr}, {16'd0, b.xr});
                check("xi", {16'd0, xi}, {16'd0, b.xi});
                check("yr", {16'd0, yr}, {16'd0, b.yr});
                check("yi", {16'd0, yi}, {16'd0, b.yi});
                check("wr", {16'd0, wr}, {16'd0, b.wr});
                check("wi", {16'd0, wi}, {16'd0, b.wi});
                check("out_idx", {29'd0, out_idx}, {29'd0, b.idx});
                check("out_last", {31'd0, out_last}, {31'd0, b.last});
                if (out_ready) void'(exp_q.pop_front());
            end else begin
                check("out_last_idle", {31'd0, out_last}, 32'd0);
                if (in_valid) begin
                    frame_re.push_back(in_re);
                    frame_im.push_back(in_im);
                    if (frame_re.size() == 16) begin
                        for (int p = 0; p < 8; p++) begin
                            b.xr   = frame_re[p];
                            b.xi   = frame_im[p];
                            b.yr   = frame_re[p + 8];
                            b.yi   = frame_im[p + 8];
                            b.wr   = TW[p][31:16];
                            b.wi   = TW[p][15:0];
                            b.idx  = 3'(p);
                            b.last = (p == 7);
                            exp_q.push_back(b);
                        end
                        frame_re.delete();
                        frame_im.delete();
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] re, input logic [15:0] im, input bit bubble);
        bit hs;
        if (bubble) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk); #1;
            if (hs) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 300; t++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain", exp_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_beat(input logic [2:0] idx);
        for (int t = 0; t < 50; t++) begin
            if (out_valid && out_idx == idx) return;
            @(posedge clk); #1;
        end
        check("wait_beat_timeout", 32'd0, 32'd1);
    endtask

    // Asserts reset off-edge and checks the asynchronous effect before any clock
    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_xr", {16'd0, xr}, 32'd0);
        check("rst_xi", {16'd0, xi}, 32'd0);
        check("rst_yr", {16'd0, yr}, 32'd0);
        check("rst_yi", {16'd0, yi}, 32'd0);
        check("rst_wr", {16'd0, wr}, 32'd0);
        check("rst_wi", {16'd0, wi}, 32'd0);
        check("rst_idx", {29'd0, out_idx}, 32'd0);
        check("rst_last", {31'd0, out_last}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b1;
        #3;
        reset_pulse();

        // Ramp frame i / -i, no backpressure
        for (int i = 0; i < 16; i++) send(16'(i), 16'(-i), 1'b0);
        check("ramp_beat0_xr", {16'd0, xr}, 32'd0);
        check("ramp_beat0_yr", {16'd0, yr}, 32'd8);
        drain();

        // Backpressure on beat 2
        for (int i = 0; i < 16; i++) send(16'(i), 16'(-i), 1'b0);
        wait_beat(3'd2);
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_xr", {16'd0, xr}, 32'd2);
            check("bp_yr", {16'd0, yr}, 32'd10);
            check("bp_w", {wr, wi}, 32'h5A82A57E);
            check("bp_idx", {29'd0, out_idx}, 32'd2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_next_idx", {29'd0, out_idx}, 32'd3);
        drain();

        // Input bubbles
        for (int i = 0; i < 16; i++) send(16'(i), 16'(-i), 1'b1);
        drain();

        // Reset in the middle of a load
        for (int i = 0; i < 5; i++) send(16'($urandom), 16'($urandom), 1'b0);
        #1;
        reset_pulse();
        for (int i = 0; i < 16; i++) send(16'(100 + i), 16'($urandom), 1'b0);
        check("rml_xr", {16'd0, xr}, 32'd100);
        check("rml_yr", {16'd0, yr}, 32'd108);
        drain();

        // in_valid held high across ISSUE with changing data, back-to-back frames
        for (int c = 0; c < 120; c++) begin
            in_valid  = 1'b1;
            in_re     = 16'($urandom);
            in_im     = 16'($urandom);
            out_ready = ($urandom_range(0, 4) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset during beat 4
        #1;
        reset_pulse();
        for (int i = 0; i < 16; i++) send(16'($urandom), 16'($urandom), 1'b0);
        wait_beat(3'd4);
        #1;
        reset_pulse();

        // Fully random traffic
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_re     = 16'($urandom);
            in_im     = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
